// File: rtl/parking_gate_sequencer.sv
// parking_gate_sequencer
// Lane front-end for one bidirectional parking gate. Two raw optical beams
// and the badge-reader level are synchronized, the beams are debounced, and a
// beam-sequence FSM tracks car direction. It drives the barrier and produces
// the entry/exit event pulses, with class flags, for the parking controller.
//
// Ports:
//   clk, rst                 clock; asynchronous active-high reset
//   beam_a, beam_b           raw outer/inner beams (1 = blocked)
//   uni_badge                raw badge level (1 = university car)
//   is_uni_vacated_space     a university space is free
//   is_vacated_space         a free space is free
//   car_entered/car_exited   one-cycle event pulses
//   is_uni_car_entered/...   class of the last entry/exit, held between events
//   gate_open                barrier open command
//   deny                     entry refused for lack of a space of that class
//   err                      sequence fault or timeout
module parking_gate_sequencer #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int TIMEOUT_CYCLES  = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic beam_a,
    input  logic beam_b,
    input  logic uni_badge,
    input  logic is_uni_vacated_space,
    input  logic is_vacated_space,
    output logic car_entered,
    output logic is_uni_car_entered,
    output logic car_exited,
    output logic is_uni_car_exited,
    output logic gate_open,
    output logic deny,
    output logic err
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {
        IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A, FAULT
    } state_t;

    // bit 0 = beam_a, bit 1 = beam_b, bit 2 = uni_badge
    logic [2:0]      sync_meta;
    logic [2:0]      sync_q;
    logic [1:0]      filt;
    logic [DB_W-1:0] db_cnt [2];

    state_t          state, state_nxt;
    logic            cls, cls_nxt;
    logic            granted, grant_now, grant_nxt;
    logic [TO_W-1:0] tmo;
    logic            ent_done, ext_done;
    logic            ent_pend, ext_pend;
    logic            gate_nxt, deny_nxt, err_nxt;
    logic            fa, fb, both_clr;

    assign fa       = filt[0];
    assign fb       = filt[1];
    assign both_clr = !fa && !fb;

    // Two-flop synchronizers for all three asynchronous inputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta <= '0;
            sync_q    <= '0;
        end else begin
            sync_meta <= {uni_badge, beam_b, beam_a};
            sync_q    <= sync_meta;
        end
    end

    // Beam debounce: the filtered value only follows the synchronized value
    // after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreement
    // reloads the counter, so short glitches are swallowed.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt   <= '0;
            db_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (sync_q[i] == filt[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    filt[i]   <= sync_q[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 1'b1;
                end
            end
        end
    end

    // FSM state, grant, class, timeout counter and all registered outputs.
    // Event flags load on the completing edge and the pulse follows one edge
    // later, so each class flag is stable a full cycle before its pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            cls                <= 1'b0;
            granted            <= 1'b0;
            tmo                <= '0;
            gate_open          <= 1'b0;
            deny               <= 1'b0;
            err                <= 1'b0;
            ent_pend           <= 1'b0;
            ext_pend           <= 1'b0;
            car_entered        <= 1'b0;
            car_exited         <= 1'b0;
            is_uni_car_entered <= 1'b0;
            is_uni_car_exited  <= 1'b0;
        end else begin
            state     <= state_nxt;
            cls       <= cls_nxt;
            granted   <= grant_nxt;
            gate_open <= gate_nxt;
            deny      <= deny_nxt;
            err       <= err_nxt;
            if (state_nxt != state) begin
                tmo <= '0;
            end else if (tmo != TO_MAX) begin
                tmo <= tmo + 1'b1;
            end
            if (ent_done) begin
                is_uni_car_entered <= cls;
            end
            if (ext_done) begin
                is_uni_car_exited <= cls;
            end
            ent_pend    <= ent_done;
            ext_pend    <= ext_done;
            car_entered <= ent_pend;
            car_exited  <= ext_pend;
        end
    end

    // Next-state and next-output logic. The grant is sampled every cycle in
    // ENT_A and, once seen, held until the FSM leaves the entry sequence.
    // The timeout check takes priority over every sequence transition.
    always_comb begin
        state_nxt = state;
        cls_nxt   = cls;
        grant_now = granted;
        ent_done  = 1'b0;
        ext_done  = 1'b0;

        if (state == ENT_A && (cls ? is_uni_vacated_space : is_vacated_space)) begin
            grant_now = 1'b1;
        end

        if (state != IDLE && state != FAULT && tmo == TO_MAX) begin
            state_nxt = FAULT;
        end else begin
            case (state)
                IDLE: begin
                    if (fa && fb) begin
                        state_nxt = FAULT;
                    end else if (fa) begin
                        state_nxt = ENT_A;
                        cls_nxt   = sync_q[2];
                    end else if (fb) begin
                        state_nxt = EXT_B;
                        cls_nxt   = sync_q[2];
                    end
                end
                ENT_A: begin
                    if (both_clr)                state_nxt = IDLE;
                    else if (fb && !grant_now)   state_nxt = FAULT;
                    else if (fa && fb)           state_nxt = ENT_AB;
                end
                ENT_AB: begin
                    if (both_clr)                state_nxt = FAULT;
                    else if (fb && !fa)          state_nxt = ENT_B;
                    else if (fa && !fb)          state_nxt = ENT_A;
                end
                ENT_B: begin
                    if (both_clr) begin
                        state_nxt = IDLE;
                        ent_done  = 1'b1;
                    end else if (fa && fb) begin
                        state_nxt = ENT_AB;
                    end else if (fa) begin
                        state_nxt = FAULT;
                    end
                end
                EXT_B: begin
                    if (both_clr)                state_nxt = IDLE;
                    else if (fa && fb)           state_nxt = EXT_AB;
                end
                EXT_AB: begin
                    if (both_clr)                state_nxt = FAULT;
                    else if (fa && !fb)          state_nxt = EXT_A;
                    else if (fb && !fa)          state_nxt = EXT_B;
                end
                EXT_A: begin
                    if (both_clr) begin
                        state_nxt = IDLE;
                        ext_done  = 1'b1;
                    end else if (fa && fb) begin
                        state_nxt = EXT_AB;
                    end else if (fb) begin
                        state_nxt = FAULT;
                    end
                end
                FAULT: begin
                    if (both_clr)                state_nxt = IDLE;
                end
                default: state_nxt = FAULT;
            endcase
        end

        grant_nxt = (state_nxt == IDLE || state_nxt == FAULT) ? 1'b0 : grant_now;
        gate_nxt  = ((state_nxt == ENT_A || state_nxt == ENT_AB || state_nxt == ENT_B) && grant_nxt)
                    || state_nxt == EXT_B || state_nxt == EXT_AB || state_nxt == EXT_A;
        deny_nxt  = (state == ENT_A) && (state_nxt == ENT_A) && !grant_now;
        err_nxt   = (state_nxt == FAULT);
    end

endmodule

// File: doc/parking_gate_sequencer.md
# parking_gate_sequencer

Lane front-end for one bidirectional parking gate. It filters two raw optical beams and a badge-reader level, and tracks car direction with a beam-sequence state machine. It drives the barrier and emits the car_entered/car_exited event pulses, with their university/free class flags, that the parking controller counts. Entry is granted only when the controller's availability flag for the car's class is set.

## Interface
- DEBOUNCE_CYCLES, 4: cycles a synchronized beam must hold a new value before its filtered value changes (≥1).
- TIMEOUT_CYCLES, 1000: maximum cycles allowed in any non-IDLE, non-FAULT state (≥2).
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- beam_a  in  1  outer beam, raw and asynchronous; 1 = blocked.
- beam_b  in  1  inner beam, raw and asynchronous; 1 = blocked.
- uni_badge  in  1  badge reader level, asynchronous; 1 = university car present.
- is_uni_vacated_space  in  1  a university space is available.
- is_vacated_space  in  1  a free space is available.
- car_entered  out  1  one-cycle entry event pulse.
- is_uni_car_entered  out  1  class of the last entry; stable around the pulse.
- car_exited  out  1  one-cycle exit event pulse.
- is_uni_car_exited  out  1  class of the last exit; stable around the pulse.
- gate_open  out  1  barrier open command.
- deny  out  1  entry refused because no space of the car's class is free.
- err  out  1  sequence fault or timeout.

## Operation
- beam_a, beam_b and uni_badge each pass through a 2-flop synchronizer.
- Each beam then goes through a debounce counter that reloads when the synchronized value equals the filtered value. The filtered value flips when DEBOUNCE_CYCLES consecutive mismatches are seen. The names fa and fb below refer to the filtered beams.
- FSM states: IDLE, ENT_A, ENT_AB, ENT_B, EXT_B, EXT_AB, EXT_A, FAULT.
- IDLE:
  - fa only → ENT_A; latch cls from synchronized uni_badge.
  - fb only → EXT_B; latch cls the same way.
  - fa and fb both set in the same cycle → FAULT.
- ENT_A:
  - Grant condition: cls ? is_uni_vacated_space : is_vacated_space. Evaluated every cycle until granted.
  - Once granted, the grant is held until the FSM returns to IDLE.
  - Granted and fa&fb → ENT_AB.
  - Both beams clear → IDLE (abort, no event).
  - fb without a grant → FAULT.
- ENT_AB:
  - fb only → ENT_B.
  - fa only → ENT_A (car reversed; grant kept).
  - Both clear → FAULT.
- ENT_B:
  - Both clear → IDLE and emit an entry event.
  - fa&fb → ENT_AB.
  - fa only → FAULT.
- Exit states mirror the entry states with the roles of a and b swapped:
  - EXT_B, EXT_AB and EXT_A follow the same transitions as ENT_A, ENT_AB and ENT_B respectively.
  - Exit is always granted; there is no availability check.
  - Completion (EXT_A → both clear) emits an exit event.
- Timeout:
  - A counter resets on every state change.
  - Reaching TIMEOUT_CYCLES in any state other than IDLE or FAULT → FAULT.
- FAULT:
  - err=1 and gate_open=0; no event is emitted.
  - Returns to IDLE once both beams are clear; err drops on that transition.
- Outputs (all registered):
  - gate_open = granted in the ENT_* states, or any EXT_* state.
  - deny = 1 in ENT_A while not granted; it drops the cycle after the grant or on exit from ENT_A.
- Event emission:
  - Edge E (the completing transition): is_uni_car_entered (or is_uni_car_exited) ← cls.
  - Edge E+1: car_entered (or car_exited) ← 1.
  - Edge E+2: pulse ← 0.
  - The class flag holds its value until the next event of the same direction, so it is stable one full cycle before the pulse rises.
- car_entered and car_exited are never high in the same cycle.

## Timing
- Reset values:
  - all outputs 0
  - state IDLE
  - fa=fb=0
  - cls=0
  - debounce and timeout counters 0
  - pulse pipeline cleared
- Reset is honoured in any state, including mid-sequence and mid-pulse. No event is emitted after reset asserts.
- Latency from a raw beam edge to a filtered edge: 2 sync cycles + DEBOUNCE_CYCLES, ±1 cycle. Raw glitches shorter than DEBOUNCE_CYCLES never reach fa or fb.
- State transitions take effect at the edge following the filtered condition.
- gate_open follows the grant with a 1-cycle register delay.
- Event pulse rises 2 edges after the last filtered beam clears.
- A new event cannot complete within the 2-cycle pulse pipeline, because completion requires a fresh debounced sequence.
- The timeout counter width is the minimum needed to hold TIMEOUT_CYCLES and saturates at that value; it does not wrap.

## Test plan
- Uni entry with is_uni_vacated_space=1:
  - Stimulus: uni_badge=1; raw sequence A, AB, B, clear, each phase 20 cycles.
  - Required: gate_open high from ENT_A+1; is_uni_car_entered=1 one cycle before car_entered pulses exactly once for 1 cycle; deny never set.
- Free entry with is_vacated_space=0:
  - Stimulus: A blocked for 50 cycles, then is_vacated_space→1, then the rest of the sequence.
  - Required: deny=1 and gate_open=0 while waiting; deny drops and gate_open rises after the grant; exactly one car_entered with is_uni_car_entered=0.
- Exit of a uni car:
  - Stimulus: uni_badge=1; raw sequence B, AB, A, clear; both availability inputs 0.
  - Required: gate_open=1 throughout; one car_exited with is_uni_car_exited=1; car_entered stays 0.
- Glitches and aborts:
  - 3-cycle raw pulses on beam_a with DEBOUNCE_CYCLES=4 → no state change and no outputs.
  - A blocked then cleared → return to IDLE with no event.
  - A, AB, A, clear → no event.
- Fault and timeout:
  - Both beams blocked simultaneously from IDLE → err=1; err clears only after both beams are clear.
  - A held for TIMEOUT_CYCLES → FAULT, gate_open=0.
- Reset mid-sequence:
  - Stimulus: assert rst in ENT_B and on the cycle between edge E and edge E+1.
  - Required: all outputs 0 immediately; no car_entered pulse; normal operation afterward.
